// File: rtl/event_mask_decoder.sv
// rtl/event_mask_decoder.sv - buffers crossing-mask words and serialises each set bit into a timestamped event
module event_mask_decoder #(
  parameter int NUM_CHANNELS = 16,
  parameter int TS_WIDTH     = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [NUM_CHANNELS-1:0] event_mask1,
  input  logic [NUM_CHANNELS-1:0] event_mask2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TS_WIDTH+3:0]     out_ts,
  output logic                    out_pileup,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [TS_WIDTH-1:0]     r_coarse;

  logic [TS_WIDTH-1:0]     r_fifo_coarse [FIFO_DEPTH];
  logic [NUM_CHANNELS-1:0] r_fifo_m1     [FIFO_DEPTH];
  logic [NUM_CHANNELS-1:0] r_fifo_m2     [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic [NUM_CHANNELS-1:0] r_rem_mask;
  logic [NUM_CHANNELS-1:0] r_m2;
  logic [TS_WIDTH-1:0]     r_work_coarse;

  logic                    r_overflow;
  logic [15:0]             r_drop_cnt;

  logic                    w_push_req;
  logic                    w_push_ok;
  logic                    w_drop;
  logic                    w_pop;
  logic                    w_empty;
  logic                    w_fire;
  logic [3:0]              w_idx;
  logic [4:0]              w_nxt;
  logic [NUM_CHANNELS-1:0] w_rem_clr;
  logic                    w_pileup;

  assign w_empty    = (r_count == '0);
  assign w_push_req = valid_in && (event_mask1 != '0);
  // A word may enter a full FIFO when the serialiser takes the head in the same cycle.
  assign w_push_ok  = w_push_req && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  assign w_drop     = w_push_req && !w_push_ok;

  assign out_valid  = (r_state == S_DRAIN);
  assign w_fire     = out_valid && out_ready;
  assign out_ts     = out_valid ? {r_work_coarse, w_idx} : '0;
  assign out_pileup = out_valid && w_pileup;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coarse <= '0;
    end else if (valid_in) begin
      r_coarse <= r_coarse + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_coarse[r_wr_ptr] <= r_coarse;
      r_fifo_m1[r_wr_ptr]     <= event_mask1;
      r_fifo_m2[r_wr_ptr]     <= event_mask2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Lowest set bit, next set bit above it (16 if none), and the pile-up window between them.
  always_comb begin
    w_idx     = '0;
    w_nxt     = 5'd16;
    w_pileup  = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (r_rem_mask[i]) begin
        w_idx = 4'(i);
      end
    end
    w_rem_clr        = r_rem_mask;
    w_rem_clr[w_idx] = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (w_rem_clr[i]) begin
        w_nxt = 5'(i);
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if ((5'(i) >= {1'b0, w_idx}) && (5'(i) < w_nxt)) begin
        w_pileup = w_pileup | r_m2[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last bit of the word leaves: refill back-to-back so there is no bubble.
        if (w_fire && (w_rem_clr == '0)) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem_mask    <= '0;
      r_m2          <= '0;
      r_work_coarse <= '0;
    end else if (w_pop) begin
      r_rem_mask    <= r_fifo_m1[r_rd_ptr];
      r_m2          <= r_fifo_m2[r_rd_ptr];
      r_work_coarse <= r_fifo_coarse[r_rd_ptr];
    end else if (w_fire) begin
      r_rem_mask    <= w_rem_clr;
    end
  end

endmodule
